fifo_packer_param: RTL and testbench
====================================

# fifo_packer_param

Parametrised packer that gathers a variable count of valid 32-bit words per cycle into full C_FIFO_WIDTH-wide words for the receive-side data FIFO. It generalises the fixed 32-bit packer to 32/64/128-bit FIFOs and adds word-count input, residual accumulation, and a flush that writes any partial word zero-padded. It sits between the RX TLP data-steering logic and the channel receive FIFO, which always has room for the writes.

## Interface
- C_FIFO_WIDTH, 128: output width in bits; legal 32, 64, 128. C_WORDS = C_FIFO_WIDTH/32.
- CLK  in  1  single clock.
- RST  in  1  reset, asynchronous, active-high; clears all state.
- DATA_IN  in  C_FIFO_WIDTH  incoming words; word 0 is bits [31:0]; valid words are packed low.
- DATA_IN_EN  in  clog2(C_WORDS)+1  number of valid words this cycle, 0..C_WORDS.
- DATA_IN_DONE  in  1  pulse: end of incoming packet.
- DATA_IN_ERR  in  1  pulse: error in incoming packet.
- DATA_IN_FLUSH  in  1  pulse: end of incoming data; emit residual.
- PACKED_DATA  out  C_FIFO_WIDTH  packed FIFO word.
- PACKED_WEN  out  1  FIFO write enable.
- PACKED_DATA_DONE  out  1  pulse, delayed DATA_IN_DONE.
- PACKED_DATA_ERR  out  1  pulse, delayed DATA_IN_ERR.
- PACKED_DATA_FLUSHED  out  1  pulse: all data including residual written.

## Operation
- Stage 1: register all inputs (rData, rEn, rDone, rErr, rFlush).
- Stage 2: accumulator of 2*C_WORDS-1 words plus residual count rCount (0..C_WORDS-1). New rEn words are appended at word offset rCount.
- If rCount + rEn >= C_WORDS: lowest C_WORDS words registered to PACKED_DATA, PACKED_WEN=1, remaining words shift down, rCount = rCount + rEn - C_WORDS. Otherwise accumulate, PACKED_WEN=0.
- At most one output word per cycle is guaranteed since rCount + rEn <= 2*C_WORDS-1.
- State machine: ACC (normal), FLUSH_WR, FLUSH_DONE.
  - ACC, rFlush=1: after that cycle's accumulate/emit, if new rCount>0 -> FLUSH_WR, else -> FLUSH_DONE.
  - FLUSH_WR: emit residual words low, upper words zero, PACKED_WEN=1, rCount=0 -> FLUSH_DONE.
  - FLUSH_DONE: PACKED_DATA_FLUSHED=1 for one cycle -> ACC.
- C_FIFO_WIDTH=32: rCount always 0; FLUSH_WR never entered; block degenerates to a 2-stage delay.
- DONE/ERR pass through the two stages unchanged, aligned with the write of the data received in the same cycle.
- Upstream rule: DATA_IN_EN=0 for the 2 cycles after DATA_IN_FLUSH; the bench flags violations with an assertion. DATA_IN_EN > C_WORDS is illegal and also asserted.

## Timing
- Reset (asynchronous): PACKED_WEN, PACKED_DATA_DONE, PACKED_DATA_ERR, PACKED_DATA_FLUSHED = 0; PACKED_DATA = 0; rCount=0; state ACC. Reset mid-packet discards the residual with no write.
- Input at cycle t -> PACKED_WEN/DONE/ERR at t+2.
- FLUSH at t with residual after stage 2 -> padded write at t+3, FLUSHED at t+4.
- FLUSH at t without residual -> FLUSHED at t+3.
- DATA_IN_EN and DATA_IN_FLUSH in the same cycle: the data is included before flush evaluation.
- DONE and FLUSH in the same cycle: DONE at t+2, FLUSHED per the rules above.

## Structure
- Shared package riffa_pkg: flush state enum (ACC, FLUSH_WR, FLUSH_DONE), word width constant 32, and a clog2 function.
- No sub-module is needed. Stage 1 is an inline register bank; the accumulator and shifter are one always_ff/always_comb pair.

## Test plan
- C_FIFO_WIDTH=128, EN=1 for 8 cycles with words 1..8 -> two writes, {4,3,2,1} at t0+5 and {8,7,6,5} at t0+9; no flush write.
- 128, EN sequence 3,3,2 (words 1..8) -> writes {4,3,2,1} then {8,7,6,5}; rCount returns to 0.
- 128, EN=3 (words A,B,C) then FLUSH next cycle -> write {0,C,B,A} at flush+3, FLUSHED at flush+4.
- 64, EN=2 with FLUSH in the same cycle -> one full write at t+2, no padded write, FLUSHED at t+3.
- 128, EN=1 DONE=1 ERR=1 -> DONE and ERR pulse at t+2 with WEN=0; residual is held.
- 128, RST asserted asynchronously with rCount=3 -> outputs are 0 immediately; a subsequent FLUSH yields no write and FLUSHED at +3.

Source files
------------

// File: rtl/riffa_pkg.sv
// Definitions shared by the RIFFA receive-path blocks: the 32-bit word size,
// the packer flush states and a constant-foldable clog2.
package riffa_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ACC,
      FLUSH_WR,
      FLUSH_DONE
   } flush_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_packer_param.sv
// Gathers 0..C_WORDS valid 32-bit words per cycle into full C_FIFO_WIDTH words
// for the RX data FIFO; a flush writes any partial word zero-padded.
module fifo_packer_param
   import riffa_pkg::*;
#(
   parameter int C_FIFO_WIDTH = 128
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic [C_FIFO_WIDTH-1:0]              DATA_IN,
   input  logic [clog2(C_FIFO_WIDTH/WORD_W):0]  DATA_IN_EN,
   input  logic                                 DATA_IN_DONE,
   input  logic                                 DATA_IN_ERR,
   input  logic                                 DATA_IN_FLUSH,
   output logic [C_FIFO_WIDTH-1:0]              PACKED_DATA,
   output logic                                 PACKED_WEN,
   output logic                                 PACKED_DATA_DONE,
   output logic                                 PACKED_DATA_ERR,
   output logic                                 PACKED_DATA_FLUSHED
);

   localparam int C_WORDS = C_FIFO_WIDTH / WORD_W;
   localparam int CW      = clog2(C_WORDS) + 1;
   localparam int ACC_W   = (2 * C_WORDS - 1) * WORD_W;
   localparam logic [CW-1:0] WORDS_CNT = CW'(C_WORDS);

   // Stage 1 registers
   logic [C_FIFO_WIDTH-1:0] r_data;
   logic [CW-1:0]           r_en;
   logic                    r_done;
   logic                    r_err;
   logic                    r_flush;

   // Stage 2 accumulator
   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        comb;
   logic [CW-1:0]           r_count;
   logic [CW-1:0]           total;
   logic [CW-1:0]           count_next;
   logic                    emit;
   flush_state_e            state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_data  <= '0;
         r_en    <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_flush <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so the two stages never race each other.
         r_data  <= DATA_IN;
         r_en    <= DATA_IN_EN;
         r_done  <= DATA_IN_DONE;
         r_err   <= DATA_IN_ERR;
         r_flush <= DATA_IN_FLUSH;
      end
   end

   // Residual words sit low; this cycle's words land directly above them.
   always_comb begin
      // NOTE: every output gets a default before the loops so no path leaves
      // a bit unassigned and no latch is inferred.
      comb = '0;
      for (int i = 0; i < 2 * C_WORDS - 1; i++) begin
         if (i < int'(r_count)) comb[i*WORD_W +: WORD_W] = acc[i*WORD_W +: WORD_W];
      end
      for (int i = 0; i < C_WORDS; i++) begin
         if (i < int'(r_en))
            comb[(int'(r_count) + i)*WORD_W +: WORD_W] = r_data[i*WORD_W +: WORD_W];
      end
      total      = r_count + r_en;
      emit       = (total >= WORDS_CNT);
      count_next = emit ? (total - WORDS_CNT) : total;
   end

   // NOTE: acc is deliberately left without reset: words at or above r_count
   // are masked in the combine step, so stale contents are never observable.
   always_ff @(posedge CLK) begin
      if (emit) acc <= comb >> C_FIFO_WIDTH;
      else      acc <= comb;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         PACKED_DATA         <= '0;
         PACKED_WEN          <= 1'b0;
         PACKED_DATA_DONE    <= 1'b0;
         PACKED_DATA_ERR     <= 1'b0;
         PACKED_DATA_FLUSHED <= 1'b0;
         r_count             <= '0;
         state               <= ACC;
      end else begin
         PACKED_DATA_DONE    <= r_done;
         PACKED_DATA_ERR     <= r_err;
         PACKED_WEN          <= 1'b0;
         PACKED_DATA_FLUSHED <= 1'b0;
         case (state)
            ACC: begin
               if (emit) begin
                  PACKED_DATA <= comb[C_FIFO_WIDTH-1:0];
                  PACKED_WEN  <= 1'b1;
               end
               r_count <= count_next;
               // Flush is judged on the count that includes this cycle's data.
               if (r_flush) state <= (count_next != '0) ? FLUSH_WR : FLUSH_DONE;
            end
            FLUSH_WR: begin
               PACKED_DATA <= comb[C_FIFO_WIDTH-1:0];
               PACKED_WEN  <= 1'b1;
               r_count     <= '0;
               state       <= FLUSH_DONE;
            end
            FLUSH_DONE: begin
               PACKED_DATA_FLUSHED <= 1'b1;
               state               <= ACC;
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_packer_param.sv
// Bench for fifo_packer_param: 128-bit and 64-bit instances driven with directed
// and random traffic, checked every cycle against a word-list model.
module tb_fifo_packer_param;

   localparam int MAXC = 2000;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // lane 0 = 128-bit instance, lane 1 = 64-bit instance
   logic [127:0] din     [2];
   logic [2:0]   en      [2];
   logic         done_i  [2];
   logic         err_i   [2];
   logic         flush_i [2];

   logic [127:0] p0_data;
   logic [63:0]  p1_data;
   logic [127:0] pdata [2];
   logic         pwen  [2];
   logic         pdone [2];
   logic         perr  [2];
   logic         pfl   [2];

   assign pdata[0] = p0_data;
   assign pdata[1] = {64'd0, p1_data};

   fifo_packer_param #(.C_FIFO_WIDTH(128)) dut128 (
      .CLK(CLK), .RST(RST),
      .DATA_IN(din[0]), .DATA_IN_EN(en[0]),
      .DATA_IN_DONE(done_i[0]), .DATA_IN_ERR(err_i[0]), .DATA_IN_FLUSH(flush_i[0]),
      .PACKED_DATA(p0_data), .PACKED_WEN(pwen[0]),
      .PACKED_DATA_DONE(pdone[0]), .PACKED_DATA_ERR(perr[0]), .PACKED_DATA_FLUSHED(pfl[0])
   );

   fifo_packer_param #(.C_FIFO_WIDTH(64)) dut64 (
      .CLK(CLK), .RST(RST),
      .DATA_IN(din[1][63:0]), .DATA_IN_EN(en[1][1:0]),
      .DATA_IN_DONE(done_i[1]), .DATA_IN_ERR(err_i[1]), .DATA_IN_FLUSH(flush_i[1]),
      .PACKED_DATA(p1_data), .PACKED_WEN(pwen[1]),
      .PACKED_DATA_DONE(pdone[1]), .PACKED_DATA_ERR(perr[1]), .PACKED_DATA_FLUSHED(pfl[1])
   );

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int nwords(input int ln);
      return (ln == 0) ? 4 : 2;
   endfunction

   // Stimulus for the next cycle, consumed and cleared by step()
   logic [127:0] s_data  [2];
   int           s_en    [2];
   logic         s_done  [2];
   logic         s_err   [2];
   logic         s_flush [2];

   // Model: pending word list per lane plus expected outputs indexed by cycle
   logic [31:0]  pend    [2][8];
   int           pend_n  [2];
   logic         exp_wen [2][MAXC];
   logic         exp_done[2][MAXC];
   logic         exp_err [2][MAXC];
   logic         exp_fl  [2][MAXC];
   logic [127:0] exp_data[2][MAXC];
   logic [127:0] hold    [2];

   task automatic model_in(input int ln, input int t);
      logic [127:0] w;
      int n;
      n = nwords(ln);
      for (int i = 0; i < s_en[ln]; i++) begin
         pend[ln][pend_n[ln]] = s_data[ln][i*32 +: 32];
         pend_n[ln]++;
      end
      if (s_done[ln]) exp_done[ln][t+2] = 1'b1;
      if (s_err[ln])  exp_err[ln][t+2]  = 1'b1;
      if (pend_n[ln] >= n) begin
         w = '0;
         for (int i = 0; i < n; i++) w[i*32 +: 32] = pend[ln][i];
         for (int i = n; i < pend_n[ln]; i++) pend[ln][i-n] = pend[ln][i];
         pend_n[ln] -= n;
         exp_wen[ln][t+2]  = 1'b1;
         exp_data[ln][t+2] = w;
      end
      if (s_flush[ln]) begin
         if (pend_n[ln] > 0) begin
            w = '0;
            for (int i = 0; i < pend_n[ln]; i++) w[i*32 +: 32] = pend[ln][i];
            pend_n[ln]        = 0;
            exp_wen[ln][t+3]  = 1'b1;
            exp_data[ln][t+3] = w;
            exp_fl[ln][t+4]   = 1'b1;
         end else begin
            exp_fl[ln][t+3] = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      for (int ln = 0; ln < 2; ln++) begin
         din[ln]     = s_data[ln];
         en[ln]      = 3'(s_en[ln]);
         done_i[ln]  = s_done[ln];
         err_i[ln]   = s_err[ln];
         flush_i[ln] = s_flush[ln];
         if (!RST) model_in(ln, cyc);
         s_data[ln]  = '0;
         s_en[ln]    = 0;
         s_done[ln]  = 1'b0;
         s_err[ln]   = 1'b0;
         s_flush[ln] = 1'b0;
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) step();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      step();
      #2;
      RST = 1'b1;
      for (int ln = 0; ln < 2; ln++) begin
         pend_n[ln] = 0;
         hold[ln]   = '0;
         for (int c = cyc; c < MAXC; c++) begin
            exp_wen[ln][c]  = 1'b0;
            exp_done[ln][c] = 1'b0;
            exp_err[ln][c]  = 1'b0;
            exp_fl[ln][c]   = 1'b0;
         end
      end
      #1;
      check("async reset wen",  128'(pwen[0]),  128'd0);
      check("async reset data", pdata[0],       128'd0);
      check("async reset done", 128'(pdone[0]), 128'd0);
      check("async reset err",  128'(perr[0]),  128'd0);
      check("async reset fl",   128'(pfl[0]),   128'd0);
      @(negedge CLK);
      #2;
      RST = 1'b0;
   endtask

   // Upstream rules on the input side
   logic [1:0] fd1 = '0;
   logic [1:0] fd2 = '0;
   always @(posedge CLK) begin
      if (!RST) begin
         assert (en[0] <= 3'd4) else $error("lane0 word count above 4");
         assert (en[1] <= 3'd2) else $error("lane1 word count above 2");
         if (fd1[0] || fd2[0]) assert (en[0] == 3'd0) else $error("lane0 data after flush");
         if (fd1[1] || fd2[1]) assert (en[1] == 3'd0) else $error("lane1 data after flush");
      end
      fd1 <= {flush_i[1], flush_i[0]};
      fd2 <= fd1;
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (chk_on) begin
         for (int ln = 0; ln < 2; ln++) begin
            if (exp_wen[ln][cyc]) hold[ln] = exp_data[ln][cyc];
            check($sformatf("lane%0d wen @%0d", ln, cyc),  128'(pwen[ln]),  128'(exp_wen[ln][cyc]));
            check($sformatf("lane%0d done @%0d", ln, cyc), 128'(pdone[ln]), 128'(exp_done[ln][cyc]));
            check($sformatf("lane%0d err @%0d", ln, cyc),  128'(perr[ln]),  128'(exp_err[ln][cyc]));
            check($sformatf("lane%0d flushed @%0d", ln, cyc), 128'(pfl[ln]), 128'(exp_fl[ln][cyc]));
            check($sformatf("lane%0d data @%0d", ln, cyc), pdata[ln], hold[ln]);
         end
      end
   end

   int t;
   int gap [2];

   initial begin
      for (int ln = 0; ln < 2; ln++) begin
         din[ln] = '0; en[ln] = '0; done_i[ln] = 1'b0; err_i[ln] = 1'b0; flush_i[ln] = 1'b0;
         s_data[ln] = '0; s_en[ln] = 0; s_done[ln] = 1'b0; s_err[ln] = 1'b0; s_flush[ln] = 1'b0;
         pend_n[ln] = 0;
         hold[ln]   = '0;
         gap[ln]    = 10;
         for (int c = 0; c < MAXC; c++) begin
            exp_wen[ln][c] = 1'b0; exp_done[ln][c] = 1'b0; exp_err[ln][c] = 1'b0;
            exp_fl[ln][c]  = 1'b0; exp_data[ln][c] = '0;
         end
      end

      repeat (2) @(negedge CLK);
      for (int ln = 0; ln < 2; ln++) begin
         check($sformatf("reset wen lane%0d", ln),  128'(pwen[ln]),  128'd0);
         check($sformatf("reset data lane%0d", ln), pdata[ln],       128'd0);
         check($sformatf("reset fl lane%0d", ln),   128'(pfl[ln]),   128'd0);
      end
      RST    = 1'b0;
      chk_on = 1'b1;
      step();

      // 128: one word per cycle, words 1..8
      t = 0;
      for (int i = 1; i <= 8; i++) begin
         s_en[0] = 1; s_data[0] = 128'(i);
         step();
         if (i == 1) t = cyc;
      end
      check("pin single wen1",  128'(exp_wen[0][t+5]), 128'd1);
      check("pin single data1", exp_data[0][t+5], 128'h00000004_00000003_00000002_00000001);
      check("pin single wen2",  128'(exp_wen[0][t+9]), 128'd1);
      check("pin single data2", exp_data[0][t+9], 128'h00000008_00000007_00000006_00000005);
      repeat (4) step();

      // 128: counts 3,3,2 then flush with nothing left
      s_en[0] = 3; s_data[0] = 128'h00000003_00000002_00000001; step(); t = cyc;
      s_en[0] = 3; s_data[0] = 128'h00000006_00000005_00000004; step();
      s_en[0] = 2; s_data[0] = 128'h00000008_00000007;          step();
      s_flush[0] = 1'b1; step();
      check("pin 332 data1", exp_data[0][t+3], 128'h00000004_00000003_00000002_00000001);
      check("pin 332 data2", exp_data[0][t+4], 128'h00000008_00000007_00000006_00000005);
      check("pin 332 no pad", 128'(exp_wen[0][t+6]), 128'd0);
      wait_cyc(t + 6);
      check("332 flushed", 128'(pfl[0]), 128'd1);
      check("332 no pad write", 128'(pwen[0]), 128'd0);
      repeat (2) step();

      // 128: three words then flush -> padded write
      s_en[0] = 3; s_data[0] = 128'h0000000C_0000000B_0000000A; step();
      s_flush[0] = 1'b1; step(); t = cyc;
      check("pin pad data", exp_data[0][t+3], 128'h00000000_0000000C_0000000B_0000000A);
      check("pin pad fl",   128'(exp_fl[0][t+4]), 128'd1);
      wait_cyc(t + 3);
      check("pad wen",  128'(pwen[0]), 128'd1);
      check("pad data", pdata[0], 128'h00000000_0000000C_0000000B_0000000A);
      wait_cyc(t + 4);
      check("pad flushed", 128'(pfl[0]), 128'd1);
      repeat (2) step();

      // 64: full word and flush in the same cycle
      s_en[1] = 2; s_data[1] = 128'h00000022_00000011; s_flush[1] = 1'b1; step(); t = cyc;
      wait_cyc(t + 2);
      check("w64 wen",  128'(pwen[1]), 128'd1);
      check("w64 data", pdata[1], 128'h00000022_00000011);
      wait_cyc(t + 3);
      check("w64 no pad", 128'(pwen[1]), 128'd0);
      check("w64 flushed", 128'(pfl[1]), 128'd1);
      repeat (2) step();

      // 128: done/err ride with a partial word
      s_en[0] = 1; s_data[0] = 128'h55; s_done[0] = 1'b1; s_err[0] = 1'b1; step(); t = cyc;
      wait_cyc(t + 2);
      check("done pulse", 128'(pdone[0]), 128'd1);
      check("err pulse",  128'(perr[0]),  128'd1);
      check("done no wen", 128'(pwen[0]), 128'd0);

      // 128: build residual of 3, reset, then flush finds nothing
      s_en[0] = 2; s_data[0] = 128'h00000077_00000066; step(); t = cyc;
      wait_cyc(t + 3);
      do_reset();
      s_flush[0] = 1'b1; step(); t = cyc;
      wait_cyc(t + 3);
      check("post-reset flushed", 128'(pfl[0]), 128'd1);
      check("post-reset no write", 128'(pwen[0]), 128'd0);
      repeat (3) step();

      // Random traffic on both lanes
      for (int k = 0; k < 600; k++) begin
         if (k == 300) do_reset();
         for (int ln = 0; ln < 2; ln++) begin
            if (gap[ln] < 2) s_en[ln] = 0;
            else s_en[ln] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, nwords(ln)));
            s_data[ln]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_done[ln]  = ($urandom_range(0, 9) == 0);
            s_err[ln]   = ($urandom_range(0, 9) == 0);
            s_flush[ln] = (gap[ln] >= 4) && ($urandom_range(0, 15) == 0);
            gap[ln]     = s_flush[ln] ? 0 : gap[ln] + 1;
         end
         step();
      end

      repeat (8) step();
      @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
